mac_tile_dual: RTL and testbench

Parametrised successor processing element for the systolic MAC array. It supports two dataflows selected per run:
- weight-stationary (WS): a kernel is loaded once and partial sums flow north→south.
- output-stationary (OS): weights stream north→south, each tile accumulates locally, and results are drained down the column.

Activations and instructions flow west→east, one register stage per tile.

---
 rtl/mac_pkg.sv | 16 +
 rtl/mac_tile_dual_mac.sv | 30 +++
 rtl/mac_tile_dual.sv | 99 +++++++++
 tb/tb_mac_tile_dual.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared encodings and default widths for the systolic MAC tile family.
package mac_pkg;

  localparam int INST_LOAD  = 0;
  localparam int INST_EXEC  = 1;
  localparam int INST_DRAIN = 2;

  localparam int BW_DEF      = 4;
  localparam int PSUM_BW_DEF = 16;

  typedef enum logic {
    MODE_WS = 1'b0,
    MODE_OS = 1'b1
  } mode_e;

endpackage

// File: rtl/mac_tile_dual_mac.sv
// Combinational multiply-accumulate: out = c + signed(0,a) * signed(b), wrapping at psum_bw.
module mac
  import mac_pkg::*;
#(
  parameter int bw      = BW_DEF,
  parameter int psum_bw = PSUM_BW_DEF
) (
  input  logic        [bw-1:0]      a,
  input  logic signed [bw-1:0]      b,
  input  logic signed [psum_bw-1:0] c,
  output logic signed [psum_bw-1:0] out
);

  // Activation is zero-extended by one bit so the signed multiply treats it as unsigned.
  function automatic logic signed [psum_bw-1:0] sext_product(
    input logic        [bw-1:0] a_u,
    input logic signed [bw-1:0] w
  );
    logic signed [bw:0]   a_s;
    logic signed [2*bw:0] p;
    a_s = signed'({1'b0, a_u});
    p   = (2*bw+1)'(a_s) * (2*bw+1)'(w);
    return psum_bw'(p);
  endfunction

  always_comb begin
    out = c + sext_product(a, b);
  end

endmodule

// File: rtl/mac_tile_dual.sv
// Dual-dataflow systolic PE: weight-stationary (psum flows south) or output-stationary (local acc, drained south).
module mac_tile_dual
  import mac_pkg::*;
#(
  parameter int bw      = BW_DEF,
  parameter int psum_bw = PSUM_BW_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      mode,
  input  logic        [bw-1:0]      in_w,
  output logic        [bw-1:0]      out_e,
  input  logic        [2:0]         inst_w,
  output logic        [2:0]         inst_e,
  input  logic signed [psum_bw-1:0] in_n,
  output logic signed [psum_bw-1:0] out_s
);

  mode_e                      mode_q;
  logic                       load_ready;
  logic                       drained;
  logic signed [bw-1:0]       b_q;
  logic signed [psum_bw-1:0]  acc;

  logic signed [bw-1:0]       mac_b;
  logic signed [psum_bw-1:0]  mac_c;
  logic signed [psum_bw-1:0]  mac_out;

  // OS takes the weight from the north bus and accumulates locally; WS uses the loaded kernel and incoming psum.
  always_comb begin
    mac_b = b_q;
    mac_c = in_n;
    if (mode_q == MODE_OS) begin
      mac_b = in_n[bw-1:0];
      mac_c = acc;
    end
  end

  mac #(
    .bw      (bw),
    .psum_bw (psum_bw)
  ) u_mac (
    .a   (in_w),
    .b   (mac_b),
    .c   (mac_c),
    .out (mac_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      out_e      <= '0;
      inst_e     <= '0;
      out_s      <= '0;
      acc        <= '0;
      b_q        <= '0;
      load_ready <= 1'b1;
      mode_q     <= MODE_WS;
      drained    <= 1'b0;
    end else if (inst_w == 3'b000) begin
      mode_q  <= mode_e'(mode);
      inst_e  <= '0;
      drained <= 1'b0;
    end else begin
      out_e              <= in_w;
      inst_e[INST_EXEC]  <= inst_w[INST_EXEC];
      inst_e[INST_DRAIN] <= inst_w[INST_DRAIN];
      inst_e[INST_LOAD]  <= 1'b0;
      if (inst_w[INST_DRAIN]) begin
        // Only the first drain cycle of a burst emits this tile's acc; afterwards it forwards results from above.
        if (mode_q == MODE_OS && !drained) begin
          out_s   <= acc;
          acc     <= '0;
          drained <= 1'b1;
        end else begin
          out_s <= in_n;
        end
      end else begin
        drained <= 1'b0;
        if (inst_w[INST_EXEC]) begin
          if (mode_q == MODE_OS) begin
            acc   <= mac_out;
            out_s <= in_n;
          end else begin
            out_s <= mac_out;
          end
        end else if (mode_q == MODE_WS) begin
          // The first load pulse is consumed here; later ones travel east to the next tile.
          if (load_ready) begin
            b_q        <= in_w;
            load_ready <= 1'b0;
          end else begin
            inst_e[INST_LOAD] <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_tile_dual.sv
// Scoreboarded bench for mac_tile_dual: directed scenarios plus random traffic against a behavioural tile model.
module tb_mac_tile_dual;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mode = 1'b0;
  logic [3:0]  in_w = '0;
  logic [3:0]  out_e;
  logic [2:0]  inst_w = '0;
  logic [2:0]  inst_e;
  logic [15:0] in_n = '0;
  logic [15:0] out_s;

  logic        reset8 = 1'b1;
  logic        mode8 = 1'b0;
  logic [3:0]  in_w8 = '0;
  logic [3:0]  out_e8;
  logic [2:0]  inst_w8 = '0;
  logic [2:0]  inst_e8;
  logic [7:0]  in_n8 = '0;
  logic [7:0]  out_s8;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] out_s;
    logic [3:0]  out_e;
    logic [2:0]  inst_e;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state
  int          m_acc;
  int          m_b;
  bit          m_ready;
  bit          m_mode;
  bit          m_drained;
  exp_t        m_out;

  always #5 clk = ~clk;

  mac_tile_dual #(.bw(4), .psum_bw(16)) dut (
    .clk    (clk),
    .reset  (reset),
    .mode   (mode),
    .in_w   (in_w),
    .out_e  (out_e),
    .inst_w (inst_w),
    .inst_e (inst_e),
    .in_n   (in_n),
    .out_s  (out_s)
  );

  mac_tile_dual #(.bw(4), .psum_bw(8)) dut8 (
    .clk    (clk),
    .reset  (reset8),
    .mode   (mode8),
    .in_w   (in_w8),
    .out_e  (out_e8),
    .inst_w (inst_w8),
    .inst_e (inst_e8),
    .in_n   (in_n8),
    .out_s  (out_s8)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic int signed4(input int v);
    int s;
    s = v & 15;
    if (s >= 8) s = s - 16;
    return s;
  endfunction

  function automatic void model_reset();
    m_acc = 0; m_b = 0; m_ready = 1; m_mode = 0; m_drained = 0;
    m_out.out_s = '0; m_out.out_e = '0; m_out.inst_e = '0;
  endfunction

  // Applies one clock of the tile's behaviour to the model, in arithmetic terms.
  function automatic void model_step(input bit r, input bit md, input int a, input int ins, input int n);
    if (r) begin
      model_reset();
      return;
    end
    if (ins == 0) begin
      m_mode = md;
      m_out.inst_e = 3'b000;
      m_drained = 0;
      return;
    end
    m_out.out_e = 4'(a);
    m_out.inst_e = {ins[2], ins[1], 1'b0};
    if (ins[2]) begin
      if (m_mode && !m_drained) begin
        m_out.out_s = 16'(m_acc);
        m_acc = 0;
        m_drained = 1;
      end else begin
        m_out.out_s = 16'(n);
      end
    end else begin
      m_drained = 0;
      if (ins[1]) begin
        if (m_mode) begin
          m_acc = (m_acc + a * signed4(n)) & 16'hFFFF;
          m_out.out_s = 16'(n);
        end else begin
          m_out.out_s = 16'((n + a * signed4(m_b)) & 16'hFFFF);
        end
      end else if (!m_mode) begin
        if (m_ready) begin
          m_b = a;
          m_ready = 0;
        end else begin
          m_out.inst_e[0] = 1'b1;
        end
      end
    end
  endfunction

  task automatic drive(input bit r, input bit md, input int a, input int ins, input int n);
    @(posedge clk);
    #3;
    reset  = r;
    mode   = md;
    in_w   = 4'(a);
    inst_w = 3'(ins);
    in_n   = 16'(n);
    model_step(r, md, a & 15, ins & 7, n & 16'hFFFF);
    exp_q.push_back(m_out);
  endtask

  // Monitor: each cycle the tile presents registered outputs for the inputs of the previous cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("out_s", int'(out_s), int'(e.out_s));
        check("out_e", int'(out_e), int'(e.out_e));
        check("inst_e", int'(inst_e), int'(e.inst_e));
      end
    end
  end

  initial begin
    int wait_cycles;
    model_reset();

    // WS: kernel -3 loaded, second pulse propagates, then execute 5*(-3)+100 = 85
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 4'hD, 3'b001, 0);
    drive(0, 0, 4'h7, 3'b001, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 5, 3'b010, 100);
    drive(0, 0, 15, 3'b010, 16'hFFF0);
    drive(0, 0, 0, 0, 0);

    // OS: accumulate 107, drain it, forward 42, restart from 0
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    drive(0, 1, 2, 3'b010, 3);
    drive(0, 1, 4, 3'b010, 16'h000F);
    drive(0, 1, 15, 3'b010, 7);
    drive(0, 1, 0, 3'b100, 0);
    drive(0, 1, 0, 3'b100, 42);
    drive(0, 1, 1, 3'b010, 1);
    // Execute+drain together: drain only
    drive(0, 1, 9, 3'b110, 5);
    drive(0, 1, 9, 3'b110, 77);
    // Mode toggled while busy is ignored
    drive(0, 0, 3, 3'b010, 2);
    drive(0, 0, 0, 3'b100, 9);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 2, 3'b010, 50);

    // Reset in the first drain cycle
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    drive(0, 1, 6, 3'b010, 5);
    drive(1, 1, 0, 3'b100, 11);
    drive(0, 1, 0, 3'b100, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 4'hE, 3'b001, 0);
    drive(0, 0, 3, 3'b010, 1000);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      int ins;
      int sel;
      sel = int'($urandom_range(0, 9));
      case (sel)
        0, 1:    ins = 0;
        2:       ins = 3'b001;
        3, 4, 5: ins = 3'b010;
        6, 7:    ins = 3'b100;
        default: ins = int'($urandom_range(0, 7));
      endcase
      drive(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
            ins, int'($urandom_range(0, 65535)));
    end
    drive(0, 0, 0, 0, 0);

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    #2;
    check("scoreboard_drained", exp_q.size(), 0);

    // Narrow accumulator wraps: 127 + 1*1 in 8 bits
    @(posedge clk); #3; reset8 = 1'b1; inst_w8 = 3'b000;
    @(posedge clk); #3; reset8 = 1'b0; in_w8 = 4'd1; inst_w8 = 3'b001;
    @(posedge clk); #3; in_w8 = 4'd1; in_n8 = 8'd127; inst_w8 = 3'b010;
    @(posedge clk); #1;
    check("wrap8_out_s", int'(out_s8), 8'h80);
    check("wrap8_out_e", int'(out_e8), 1);
    #2; inst_w8 = 3'b000;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
